float_adder_seq: RTL and testbench
==================================

Name: float_adder_seq

Overview:
- Multi-cycle, parametrised floating-point add/subtract unit.
- Takes two normalized floats and an operation select through a valid/ready input handshake.
- Aligns, adds and normalizes one bit per cycle under a small FSM, then truncates.
- Presents the result and IEEE-style status flags through a valid/ready output handshake.
- Sits behind the FPU issue logic. Successor to the combinational adder, adding a subtract mode, guard/sticky tracking and backpressure.

Parameters:
- FLOAT_SIZE, 32, total float bit-length.
- EXPONENT_SIZE, 8, exponent field bit-length.
- MANTISSA_SIZE, 23, stored mantissa bit-length (hidden bit excluded).
- BIAS, 127, exponent bias.
- GUARD_BITS, 3, extra LSBs carried through the datapath below the mantissa LSB.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, op are valid.
- in_ready  output  1  unit can accept operands; high only in IDLE.
- a  input  FLOAT_SIZE  first operand, format [S|E|M].
- b  input  FLOAT_SIZE  second operand.
- op  input  1  0 = a+b, 1 = a-b (sign of b inverted at capture).
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- out  output  FLOAT_SIZE  result float.
- overflow  output  1  result exponent exceeded the maximum finite value.
- underflow  output  1  result exponent fell to 0 or below.
- inexact  output  1  nonzero bits were discarded anywhere in the operation.
- zero  output  1  result is zero.

Behaviour:
- Reset (rst_n low, any state, mid-operation included):
  - FSM goes to IDLE immediately; in-flight operation discarded.
  - out, overflow, underflow, inexact, zero all 0; out_valid 0; in_ready 1.
- FSM states: IDLE, SWAP, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture a and b (with b sign XOR op), then go to SWAP.
- Input classification:
  - Exponent field 0 means exact zero; mantissa ignored.
  - Inf/NaN encodings are out of scope and produce no defined result.
- Exponent width: internal exponent is signed, EXPONENT_SIZE+2 bits wide.
- Mantissa datapath width: 1 carry + 1 hidden + MANTISSA_SIZE + GUARD_BITS, plus a separate sticky bit.
- SWAP (1 cycle):
  - Order operands so that |x| >= |y|, comparing exponent first, then mantissa.
  - Compute d = ex - ey.
  - If d > MANTISSA_SIZE+GUARD_BITS+1: clear y's mantissa, set sticky = (y nonzero), set d = 0.
  - Next state is ADD if d == 0, else ALIGN.
- ALIGN (d cycles):
  - Each cycle: y >>= 1, OR the shifted-out bit into sticky, d -= 1.
  - Go to ADD when d reaches 0.
- ADD (1 cycle):
  - Equal signs: mantissas are added.
  - Different signs: y is subtracted from x; sticky acts as a borrow-in below the guard bits.
  - Result sign = sign of x.
- NORM (one action per cycle):
  - Result mantissa 0: pack +0 (sign 0), zero = 1, go to DONE.
  - Carry set: shift right 1, exp += 1, OR the dropped bit into sticky; pack; go to DONE.
  - Hidden bit set: pack; go to DONE.
  - Otherwise: shift left 1, exp -= 1, stay in NORM.
- Pack (truncation, no rounding):
  - Mantissa = bits below the hidden bit, guard bits dropped.
  - inexact = sticky | (any guard bit set).
  - exp >= 2^EXPONENT_SIZE-1: out = {sign, all-ones, 0}, overflow = 1, inexact = 1.
  - exp <= 0: out = {sign, 0, 0}, underflow = 1, zero = 1, inexact = 1.
- DONE:
  - out_valid = 1; out and flags held stable.
  - On out_ready, go to IDLE and clear out_valid.
  - in_ready stays 0 until IDLE; no back-to-back overlap.
- Latency (accept edge counted as edge 0): out_valid rises after edge 3 + d + L.
  - d = alignment cycles (0 if collapsed in SWAP).
  - L = number of left-shift NORM cycles.
  - Maximum: 3 + (MANTISSA_SIZE+GUARD_BITS+1) + (MANTISSA_SIZE+GUARD_BITS+1).
- Simultaneous events:
  - in_valid while not in IDLE is ignored (in_ready = 0).
  - out_ready while not in DONE has no effect.

Test Plan:
- 1.0+1.0: a=0x3F800000, b=0x3F800000, op=0 -> out=0x40000000, all flags 0, out_valid after edge 3.
- Alignment collapse: a=0x3F800000, b=0x30800000 (d=30) -> out=0x3F800000, inexact=1, latency 3.
- Cancellation: a=0x3FC00000, b=0x3FC00000, op=1 -> out=0x00000000, zero=1, inexact=0.
- Overflow: a=b=0x7F7FFFFF, op=0 -> out=0x7F800000, overflow=1, inexact=1.
- Underflow: a=0x00800000, b=0x00C00000, op=1 -> out=0x80000000, underflow=1, zero=1, inexact=1.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles after 0x40400000+0x3F800000 (3+1) -> out stays 0x40800000 with in_ready=0.
  - Separately, drop rst_n during ALIGN -> all outputs 0 and in_ready=1 immediately.
  - Next operation after reset returns the correct result.

Source files
------------

// File: rtl/float_adder_seq.sv
// Multi-cycle floating-point add/subtract: order operands, align one bit per cycle,
// add, normalize one bit per cycle, then truncate and pack with status flags.
module float_adder_seq #(
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int BIAS          = 127,
  parameter int GUARD_BITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLOAT_SIZE-1:0] a,
  input  logic [FLOAT_SIZE-1:0] b,
  input  logic                  op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLOAT_SIZE-1:0] out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact,
  output logic                  zero
);
  localparam int MW   = MANTISSA_SIZE + GUARD_BITS + 2;
  localparam int EW   = EXPONENT_SIZE + 2;
  localparam int DMAX = MANTISSA_SIZE + GUARD_BITS + 1;
  localparam int EMAX = (1 << EXPONENT_SIZE) - 1;
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] DMAX_E = EW'(DMAX);
  localparam logic signed [EW-1:0] EMAX_E = EW'(EMAX);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E = '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SWAP  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_NORM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Returns {out, overflow, underflow, inexact, zero}; be is the biased exponent.
  function automatic logic [FLOAT_SIZE+3:0] sat_pack(input logic s,
                                                     input logic signed [EW-1:0] be,
                                                     input logic [MANTISSA_SIZE-1:0] man,
                                                     input logic inx);
    if (be >= EMAX_E)
      sat_pack = {s, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}, 4'b1010};
    else if (be <= ZERO_E)
      sat_pack = {s, {(FLOAT_SIZE-1){1'b0}}, 4'b0111};
    else
      sat_pack = {s, be[EXPONENT_SIZE-1:0], man, 2'b00, inx, 1'b0};
  endfunction

  logic [2:0]             r_state;
  logic                   r_vld;
  logic [FLOAT_SIZE-1:0]  r_out;
  logic                   r_ovf, r_unf, r_inx, r_zero;
  logic                   r_sx, r_sy, r_sticky;
  logic signed [EW-1:0]   r_ex, r_ey, r_d;
  logic [MW-1:0]          r_mx, r_my;

  // Operand unpack: a zero exponent field forces an exact zero significand.
  logic [EXPONENT_SIZE-1:0] w_ea_f, w_eb_f;
  logic                     w_a_nz, w_b_nz;
  logic signed [EW-1:0]     w_a_exp, w_b_exp;
  logic [MW-1:0]            w_a_man, w_b_man;
  assign w_ea_f  = a[FLOAT_SIZE-2 -: EXPONENT_SIZE];
  assign w_eb_f  = b[FLOAT_SIZE-2 -: EXPONENT_SIZE];
  assign w_a_nz  = |w_ea_f;
  assign w_b_nz  = |w_eb_f;
  assign w_a_exp = $signed({2'b00, w_ea_f}) - BIAS_E;
  assign w_b_exp = $signed({2'b00, w_eb_f}) - BIAS_E;
  assign w_a_man = {1'b0, w_a_nz, a[MANTISSA_SIZE-1:0] & {MANTISSA_SIZE{w_a_nz}}, {GUARD_BITS{1'b0}}};
  assign w_b_man = {1'b0, w_b_nz, b[MANTISSA_SIZE-1:0] & {MANTISSA_SIZE{w_b_nz}}, {GUARD_BITS{1'b0}}};

  logic                 w_x_ge, w_big_s, w_small_s, w_collapse;
  logic signed [EW-1:0] w_big_e, w_d;
  logic [MW-1:0]        w_big_m, w_small_m;
  assign w_x_ge     = (r_ex > r_ey) || ((r_ex == r_ey) && (r_mx >= r_my));
  assign w_big_s    = w_x_ge ? r_sx : r_sy;
  assign w_small_s  = w_x_ge ? r_sy : r_sx;
  assign w_big_e    = w_x_ge ? r_ex : r_ey;
  assign w_big_m    = w_x_ge ? r_mx : r_my;
  assign w_small_m  = w_x_ge ? r_my : r_mx;
  assign w_d        = w_x_ge ? (r_ex - r_ey) : (r_ey - r_ex);
  assign w_collapse = (w_d > DMAX_E);

  // Normalize/pack view: a carry is folded in by a one-bit right shift.
  logic                    w_carry, w_hidden, w_pinx;
  logic [MW-3:0]           w_pfrac;
  logic signed [EW-1:0]    w_pexp;
  logic [FLOAT_SIZE+3:0]   w_pack;
  assign w_carry  = r_mx[MW-1];
  assign w_hidden = r_mx[MW-2];
  assign w_pfrac  = w_carry ? r_mx[MW-2:1] : r_mx[MW-3:0];
  assign w_pexp   = (w_carry ? (r_ex + ONE_E) : r_ex) + BIAS_E;
  assign w_pinx   = r_sticky | (w_carry & r_mx[0]) | (|w_pfrac[GUARD_BITS-1:0]);
  assign w_pack   = sat_pack(r_sx, w_pexp, w_pfrac[MW-3:GUARD_BITS], w_pinx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vld   <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_inx   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) r_state <= S_SWAP;
        S_SWAP:  r_state <= (w_collapse || (w_d == ZERO_E)) ? S_ADD : S_ALIGN;
        S_ALIGN: if (r_d == ONE_E) r_state <= S_ADD;
        S_ADD:   r_state <= S_NORM;
        S_NORM: begin
          if (r_mx == '0) begin
            {r_out, r_ovf, r_unf, r_inx, r_zero} <= {{FLOAT_SIZE{1'b0}}, 2'b00, r_sticky, 1'b1};
            r_vld   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_carry || w_hidden) begin
            {r_out, r_ovf, r_unf, r_inx, r_zero} <= w_pack;
            r_vld   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_vld   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        r_sx <= a[FLOAT_SIZE-1];
        r_ex <= w_a_exp;
        r_mx <= w_a_man;
        r_sy <= b[FLOAT_SIZE-1] ^ op;
        r_ey <= w_b_exp;
        r_my <= w_b_man;
      end
      S_SWAP: begin
        r_sx <= w_big_s;
        r_sy <= w_small_s;
        r_ex <= w_big_e;
        r_mx <= w_big_m;
        if (w_collapse) begin
          r_my     <= '0;
          r_sticky <= |w_small_m;
          r_d      <= '0;
        end else begin
          r_my     <= w_small_m;
          r_sticky <= 1'b0;
          r_d      <= w_d;
        end
      end
      S_ALIGN: begin
        r_my     <= r_my >> 1;
        r_sticky <= r_sticky | r_my[0];
        r_d      <= r_d - ONE_E;
      end
      // Sticky acts as a borrow below the guard bits when magnitudes subtract.
      S_ADD: r_mx <= (r_sx == r_sy) ? (r_mx + r_my) : (r_mx - r_my - {{(MW-1){1'b0}}, r_sticky});
      S_NORM: begin
        if ((r_mx != '0) && !w_carry && !w_hidden) begin
          r_mx <= r_mx << 1;
          r_ex <= r_ex - ONE_E;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_vld;
  assign out       = r_out;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign inexact   = r_inx;
  assign zero      = r_zero;
endmodule

// File: tb/tb_float_adder_seq.sv
// Bench for float_adder_seq: exact-arithmetic reference model with truncation,
// directed vectors with literal expectations, handshake hold and mid-operation reset.
module tb_float_adder_seq;
  logic        clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, op = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, overflow, underflow, inexact, zero;
  logic [31:0] a = '0, b = '0, out;
  int          cyc = 0, nvec = 0, nerr = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {overflow, underflow, inexact, zero}
    int          lat;
    int          rise;
  } exp_t;
  exp_t q[$];

  float_adder_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .overflow(overflow), .underflow(underflow), .inexact(inexact), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  // Exact sum on a common fixed-point grid, then truncation to 24 significant bits.
  function automatic exp_t model(input logic [31:0] fa, input logic [31:0] fb, input logic fop);
    exp_t m;
    logic [299:0] va, vb, r, frac, lowmask;
    logic sa, sb, s;
    int ea, eb, ex, d, p, e;
    ea = int'(fa[30:23]);
    eb = int'(fb[30:23]);
    va = (ea == 0) ? '0 : (300'({1'b1, fa[22:0]}) << (ea - 1));
    vb = (eb == 0) ? '0 : (300'({1'b1, fb[22:0]}) << (eb - 1));
    sa = fa[31];
    sb = fb[31] ^ fop;
    if (sa == sb) begin r = va + vb; s = sa; end
    else if (va >= vb) begin r = va - vb; s = sa; end
    else begin r = vb - va; s = sb; end
    ex = (ea > eb) ? ea : eb;
    d  = (ea > eb) ? ea - eb : eb - ea;
    if (d > 27) d = 0;
    m.lat = 3 + d;
    m.rise = 0;
    p = -1;
    for (int i = 0; i < 300; i++) if (r[i]) p = i;
    if (p < 0) begin
      m.res = '0;
      m.flg = 4'b0001;
    end else begin
      e = p - 22;
      if (ex > e) m.lat += ex - e;
      if (p >= 23) begin
        lowmask = (300'(1) << (p - 23)) - 300'(1);
        frac = r >> (p - 23);
        m.flg = {2'b00, |(r & lowmask), 1'b0};
      end else begin
        frac = r << (23 - p);
        m.flg = 4'b0000;
      end
      if (e >= 255) begin
        m.res = {s, 8'hFF, 23'h0};
        m.flg = 4'b1010;
      end else if (e <= 0) begin
        m.res = {s, 31'h0};
        m.flg = 4'b0111;
      end else begin
        m.res = {s, e[7:0], frac[22:0]};
      end
    end
    return m;
  endfunction

  // Compare process: checks the result whenever out_valid is high.
  initial begin
    logic pv;
    bit   have;
    exp_t cur;
    pv = 1'b0;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        have = 1'b0;
      end else begin
        if (out_valid && !pv) begin
          if (q.size() == 0) begin
            chk("result_expected", 64'(q.size()), 64'd1);
            have = 1'b0;
          end else begin
            cur = q.pop_front();
            have = 1'b1;
            chk("latency", 64'(cyc), 64'(cur.rise));
          end
        end
        if (out_valid && have) begin
          chk("out", 64'(out), 64'(cur.res));
          chk("flags", 64'({overflow, underflow, inexact, zero}), 64'(cur.flg));
          chk("in_ready_busy", 64'(in_ready), 64'd0);
        end
        pv = out_valid;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_wait", 64'(in_ready), 64'd1);
  endtask

  task automatic run_vec(input logic [31:0] va, input logic [31:0] vb, input logic vop, input int hold);
    exp_t m;
    int n;
    wait_ready();
    m = model(va, vb, vop);
    a = va; b = vb; op = vop; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    m.rise = cyc + m.lat;
    q.push_back(m);
    in_valid = 1'b0;
    if (hold > 0) begin
      a = 32'h12345678; b = 32'h4E000000; op = 1'b1; in_valid = 1'b1;
      n = 0;
      while (!out_valid && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (!out_valid) chk("out_valid_wait", 64'(out_valid), 64'd1);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic dir(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                     input logic [31:0] lout, input logic [3:0] lflg, input int llat);
    exp_t m;
    m = model(va, vb, vop);
    chk("model_out", 64'(m.res), 64'(lout));
    chk("model_flags", 64'(m.flg), 64'(lflg));
    chk("model_lat", 64'(m.lat), 64'(llat));
    run_vec(va, vb, vop, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int n;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_out", 64'(out), 64'd0);
    chk("reset_flags", 64'({overflow, underflow, inexact, zero}), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    dir(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 3);
    dir(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4'b0010, 3);
    dir(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 4'b0001, 3);
    dir(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1010, 3);
    dir(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0111, 4);
    dir(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000, 4);
    dir(32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 4'b0000, 5);
    dir(32'h3F800000, 32'h30800000, 1'b1, 32'h3F7FFFFF, 4'b0010, 4);
    dir(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000, 5);
    dir(32'h3F800001, 32'h3F800001, 1'b0, 32'h40000001, 4'b0000, 3);
    dir(32'h3F800001, 32'h3F800000, 1'b0, 32'h40000000, 4'b0010, 3);
    dir(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000, 26);
    dir(32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 3);
    dir(32'h01000000, 32'h00000000, 1'b0, 32'h01000000, 4'b0000, 5);
    dir(32'h007FFFFF, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 3);
    run_vec(32'h3F800000, 32'h3DFFFFFF, 1'b1, 0);
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      ra[30:23] = 8'($urandom_range(100, 150));
      rb[30:23] = 8'($urandom_range(100, 150));
      run_vec(ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    // Backpressure: result must hold while out_ready is low and new operands are offered.
    run_vec(32'h40400000, 32'h3F800000, 1'b0, 10);

    // Reset in the middle of an alignment sequence.
    wait_ready();
    a = 32'h3F800000; b = 32'h3C000000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_out", 64'(out), 64'd0);
    chk("midreset_flags", 64'({overflow, underflow, inexact, zero}), 64'd0);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dir(32'h3F800000, 32'h3C000000, 1'b0, 32'h3F810000, 4'b0000, 10);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
